// File: rtl/frame_filter_if.sv
// rtl/frame_filter_if.sv - dibit stream bundle: frame dibits in, payload dibits out
interface frame_filter_if;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;

    modport master (output axiiv, axiid, input axiov, axiod);
    modport slave  (input axiiv, axiid, output axiov, axiod);
endinterface

// File: rtl/frame_filter.sv
// rtl/frame_filter.sv - RX frame filter: dest check, header strip, src/ethertype latch (opt. ETHERTYPE_CHECK_EN)
module frame_filter #(
    parameter logic [47:0] MY_ADDR      = 48'h69695A065491,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter logic [15:0] EXPECT_TYPE  = 16'h0101
) (
    input  logic           clk,
    input  logic           rst,
    frame_filter_if.slave  s,
    output logic [47:0]    src_addr,
    output logic [15:0]    ethertype,
    output logic           hdr_valid,
    output logic           frame_done,
    output logic           frame_drop
);

    typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, PAYLOAD, DROP} state_t;

`ifdef ETHERTYPE_CHECK_EN
    localparam bit TYPE_CHECK = 1'b1;
`else
    localparam bit TYPE_CHECK = 1'b0;
`endif

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [45:0] sreg, sreg_n;
    logic [47:0] src_hold, src_hold_n;
    logic [47:0] src_addr_n;
    logic [15:0] ethertype_n;
    logic        axiov_q, axiov_n;
    logic [1:0]  axiod_q, axiod_n;
    logic        hdr_valid_n, frame_done_n, frame_drop_n;

    logic [47:0] shifted;
    logic        dest_ok, type_ok;

    // Field value including the dibit arriving this cycle
    assign shifted = {sreg, s.axiid};
    assign dest_ok = (shifted == MY_ADDR) || (ACCEPT_BCAST && (shifted == 48'hFFFF_FFFF_FFFF));
    assign type_ok = !TYPE_CHECK || (shifted[15:0] == EXPECT_TYPE);

    assign s.axiov = axiov_q;
    assign s.axiod = axiod_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            src_hold   <= '0;
            src_addr   <= '0;
            ethertype  <= '0;
            axiov_q    <= 1'b0;
            axiod_q    <= '0;
            hdr_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sreg       <= sreg_n;
            src_hold   <= src_hold_n;
            src_addr   <= src_addr_n;
            ethertype  <= ethertype_n;
            axiov_q    <= axiov_n;
            axiod_q    <= axiod_n;
            hdr_valid  <= hdr_valid_n;
            frame_done <= frame_done_n;
            frame_drop <= frame_drop_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        sreg_n       = sreg;
        src_hold_n   = src_hold;
        src_addr_n   = src_addr;
        ethertype_n  = ethertype;
        axiov_n      = 1'b0;
        axiod_n      = 2'd0;
        hdr_valid_n  = 1'b0;
        frame_done_n = 1'b0;
        frame_drop_n = 1'b0;

        case (state)
            IDLE: begin
                if (s.axiiv) begin
                    sreg_n  = shifted[45:0];
                    cnt_n   = 6'd1;
                    state_n = DEST;
                end
            end
            DEST, SRC, TYPE: begin
                if (!s.axiiv) begin
                    // Truncated header
                    frame_drop_n = 1'b1;
                    cnt_n        = '0;
                    state_n      = IDLE;
                end else begin
                    sreg_n = shifted[45:0];
                    cnt_n  = cnt + 6'd1;
                    if (state == DEST && cnt == 6'd23) begin
                        if (dest_ok) begin
                            state_n = SRC;
                        end else begin
                            frame_drop_n = 1'b1;
                            state_n      = DROP;
                        end
                    end else if (state == SRC && cnt == 6'd47) begin
                        src_hold_n = shifted;
                        state_n    = TYPE;
                    end else if (state == TYPE && cnt == 6'd55) begin
                        if (type_ok) begin
                            src_addr_n  = src_hold;
                            ethertype_n = shifted[15:0];
                            hdr_valid_n = 1'b1;
                            state_n     = PAYLOAD;
                        end else begin
                            frame_drop_n = 1'b1;
                            state_n      = DROP;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (s.axiiv) begin
                    axiov_n = 1'b1;
                    axiod_n = s.axiid;
                end else begin
                    frame_done_n = 1'b1;
                    cnt_n        = '0;
                    state_n      = IDLE;
                end
            end
            DROP: begin
                if (!s.axiiv) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_filter.sv
// tb/tb_frame_filter.sv - scoreboard bench for frame_filter
module tb_frame_filter;

    localparam logic [47:0] MY_ADDR = 48'h69695A065491;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam int EV_HDR  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_DROP = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [47:0] src;
        logic [15:0] typ;
    } evt_t;

    typedef struct {
        logic [1:0] d;
        int         cyc;
    } pay_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    frame_filter_if ff_if ();
    frame_filter_if nob_if ();

    logic [47:0] src_addr, nob_src_addr;
    logic [15:0] ethertype, nob_ethertype;
    logic        hdr_valid, frame_done, frame_drop;
    logic        nob_hdr_valid, nob_frame_done, nob_frame_drop;

    assign nob_if.axiiv = ff_if.axiiv;
    assign nob_if.axiid = ff_if.axiid;

    frame_filter dut (
        .clk(clk), .rst(rst), .s(ff_if),
        .src_addr(src_addr), .ethertype(ethertype),
        .hdr_valid(hdr_valid), .frame_done(frame_done), .frame_drop(frame_drop)
    );

    frame_filter #(.ACCEPT_BCAST(1'b0)) dut_nob (
        .clk(clk), .rst(rst), .s(nob_if),
        .src_addr(nob_src_addr), .ethertype(nob_ethertype),
        .hdr_valid(nob_hdr_valid), .frame_done(nob_frame_done), .frame_drop(nob_frame_drop)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    evt_t        exp_evt[$];
    pay_t        exp_pay[$];
    logic [1:0]  pay_q[$];
    logic [47:0] exp_src = '0;
    logic [15:0] exp_type = '0;
    int          exp_nob_pay = 0, exp_nob_drop = 0;
    int          nob_pay = 0, nob_drop = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic take_evt(input int kind);
        evt_t e;
        if (exp_evt.size() == 0) begin
            check("evt_unexpected", 64'(kind), 64'd0);
        end else begin
            e = exp_evt.pop_front();
            check("evt_kind", 64'(kind), 64'(e.kind));
            check("evt_cycle", 64'(cyc), 64'(e.cyc));
            if (kind == EV_HDR) begin
                exp_src  = e.src;
                exp_type = e.typ;
            end
            check("src_addr", 64'(src_addr), 64'(exp_src));
            check("ethertype", 64'(ethertype), 64'(exp_type));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_src  = '0;
            exp_type = '0;
        end else begin
            pay_t p;
            if (!ff_if.axiov) check("axiod_idle", 64'(ff_if.axiod), 64'd0);
            if (ff_if.axiov) begin
                if (exp_pay.size() == 0) begin
                    check("pay_unexpected", 64'd1, 64'd0);
                end else begin
                    p = exp_pay.pop_front();
                    check("pay_data", 64'(ff_if.axiod), 64'(p.d));
                    check("pay_cycle", 64'(cyc), 64'(p.cyc));
                end
            end
            if (hdr_valid)  take_evt(EV_HDR);
            if (frame_done) take_evt(EV_DONE);
            if (frame_drop) take_evt(EV_DROP);
            if (nob_if.axiov) nob_pay++;
            if (nob_frame_drop) nob_drop++;
        end
    end

    task automatic push_evt(input int kind, input int c, input logic [47:0] s, input logic [15:0] t);
        exp_evt.push_back('{kind: kind, cyc: c, src: s, typ: t});
    endtask

    // trunc < 0: full frame; rst_at >= 0: assert rst while that dibit is on the wire
    task automatic send_frame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] typ,
                              input int trunc, input int rst_at);
        logic [111:0] hdr;
        logic [1:0]   d;
        int           total, dc;
        bit           acc, nob_acc, type_ok;
        hdr     = {dest, src, typ};
        total   = (trunc >= 0) ? trunc : 56 + pay_q.size();
        acc     = (dest == MY_ADDR) || (dest == BCAST);
        nob_acc = (dest == MY_ADDR);
        type_ok = 1'b1;
`ifdef ETHERTYPE_CHECK_EN
        type_ok = (typ == 16'h0101);
`endif
        for (int i = 0; i < total; i++) begin
            @(posedge clk); #1;
            d = (i < 56) ? hdr[111 - 2*i -: 2] : pay_q[i - 56];
            ff_if.axiiv = 1'b1;
            ff_if.axiid = d;
            dc = cyc;
            if (i == rst_at) begin
                @(negedge clk); #2;
                rst = 1'b1;
                #1;
                check("rst_axiov", 64'(ff_if.axiov), 64'd0);
                check("rst_axiod", 64'(ff_if.axiod), 64'd0);
                check("rst_src", 64'(src_addr), 64'd0);
                check("rst_type", 64'(ethertype), 64'd0);
                check("rst_pulses", 64'({hdr_valid, frame_done, frame_drop}), 64'd0);
                check("rst_pay_pending", 64'(exp_pay.size()), 64'd0);
                @(posedge clk); #1;
                ff_if.axiiv = 1'b0;
                ff_if.axiid = 2'd0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (i == 23 && !acc) push_evt(EV_DROP, dc + 1, '0, '0);
            if (i == 55 && acc) push_evt(type_ok ? EV_HDR : EV_DROP, dc + 1, src, typ);
            if (i >= 56 && acc && type_ok) exp_pay.push_back('{d: d, cyc: dc + 1});
            if (i >= 56 && nob_acc && type_ok) exp_nob_pay++;
        end
        @(posedge clk); #1;
        ff_if.axiiv = 1'b0;
        ff_if.axiid = 2'd0;
        dc = cyc;
        if (total < 24) push_evt(EV_DROP, dc + 1, '0, '0);
        else if (acc && total < 56) push_evt(EV_DROP, dc + 1, '0, '0);
        else if (acc && type_ok) push_evt(EV_DONE, dc + 1, '0, '0);
        if (total < 24 || !nob_acc || total < 56 || !type_ok) exp_nob_drop++;
    endtask

    task automatic rand_pay(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(2'($urandom_range(0, 3)));
    endtask

    initial begin
        ff_if.axiiv = 1'b0;
        ff_if.axiid = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_axiov", 64'(ff_if.axiov), 64'd0);
        check("reset_axiod", 64'(ff_if.axiod), 64'd0);
        check("reset_src", 64'(src_addr), 64'd0);
        check("reset_type", 64'(ethertype), 64'd0);
        check("reset_pulses", 64'({hdr_valid, frame_done, frame_drop}), 64'd0);
        rst = 1'b0;

        pay_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        send_frame(MY_ADDR, 48'h69695A065490, 16'h0101, -1, -1);
        send_frame(48'h69695A065492, 48'h0A0B0C0D0E0F, 16'h0101, -1, -1);
        rand_pay(6);
        send_frame(BCAST, 48'h0A0B0C0D0E0F, 16'h0101, -1, -1);
        send_frame(MY_ADDR, 48'h123456789ABC, 16'h0101, 30, -1);
        pay_q = '{2'd3, 2'd0, 2'd2, 2'd1};
        send_frame(MY_ADDR, 48'h69695A065490, 16'h0101, -1, -1);
        rand_pay(5);
        send_frame(MY_ADDR, 48'hA1A2A3A4A5A6, 16'h0800, -1, -1);
        pay_q.delete();
        send_frame(MY_ADDR, 48'h112233445566, 16'h0101, -1, -1);
        send_frame(MY_ADDR, 48'h112233445566, 16'h0101, 10, -1);
        rand_pay(20);
        send_frame(MY_ADDR, 48'hCAFEF00D0001, 16'h0101, -1, -1);
        pay_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        send_frame(MY_ADDR, 48'h69695A065490, 16'h0101, -1, 59);
        send_frame(MY_ADDR, 48'h69695A065490, 16'h0101, -1, -1);

        repeat (5) @(posedge clk);
        #1;
        check("evt_pending", 64'(exp_evt.size()), 64'd0);
        check("pay_pending", 64'(exp_pay.size()), 64'd0);
        check("nob_drops", 64'(nob_drop), 64'(exp_nob_drop));
        check("nob_payload", 64'(nob_pay), 64'(exp_nob_pay));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
